// File: rtl/calc_pkg.sv
// +----------------------------------------------------------------------------+
// | calc_pkg : shared types and defaults for the calculator datapath control   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package calc_pkg;

    localparam int unsigned DW_DEF      = 9;
    localparam int unsigned NREGS_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_PASS = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_A     = 3'd1,
        S_RD_B     = 3'd2,
        S_EXEC     = 3'd3,
        S_WAIT_ALU = 3'd4,
        S_WB       = 3'd5,
        S_RESP     = 3'd6
    } seq_state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_OVF = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

endpackage

`default_nettype wire

// File: rtl/seq_timeout_ctr.sv
// +----------------------------------------------------------------------------+
// | seq_timeout_ctr : clearable wait counter flagging the LIMIT-th enabled cycle|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_timeout_ctr #(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned CW    = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Raised during the LIMIT-th consecutive enabled cycle.
    assign expired = enable && (r_count == CW'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// +----------------------------------------------------------------------------+
// | alu_op_sequencer : runs one command through read A/B, ALU, write-back, rsp |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_op_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    localparam int unsigned RW     = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_opcode,
    input  logic [RW-1:0] cmd_src_a,
    input  logic [RW-1:0] cmd_src_b,
    input  logic [RW-1:0] cmd_dst,
    output logic [RW-1:0] reg_sel,
    input  logic [DW-1:0] reg_val,
    output logic          alu_start,
    output logic [2:0]    alu_opcode,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic          alu_done,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_ovf,
    output logic          wr_en,
    output logic [RW-1:0] wr_sel,
    output logic [DW-1:0] wr_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [1:0]    rsp_status,
    output logic          busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic          r_cmd_ready;
    logic          r_busy;
    logic          r_rsp_valid;
    logic [1:0]    r_status;
    logic [2:0]    r_opcode;
    logic [RW-1:0] r_src_a;
    logic [RW-1:0] r_src_b;
    logic [RW-1:0] r_dst;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [DW-1:0] r_result;
    logic          r_ovf;
    logic [RW-1:0] w_reg_sel;
    logic          w_expired;
    logic          w_in_wait;

    assign w_in_wait = (r_state == S_WAIT_ALU);

    seq_timeout_ctr #(
        .LIMIT (TIMEOUT),
        .CW    (TW)
    ) u_timeout (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (!w_in_wait),
        .enable  (w_in_wait),
        .expired (w_expired)
    );

    always_comb begin
        w_next    = r_state;
        w_reg_sel = '0;
        case (r_state)
            S_IDLE:     if (cmd_valid && r_cmd_ready) w_next = S_RD_A;
            S_RD_A: begin
                w_reg_sel = r_src_a;
                w_next    = S_RD_B;
            end
            S_RD_B: begin
                w_reg_sel = r_src_b;
                w_next    = S_EXEC;
            end
            S_EXEC:     w_next = S_WAIT_ALU;
            // A done pulse on the expiry cycle still counts as a result.
            S_WAIT_ALU: begin
                if (alu_done) begin
                    w_next = S_WB;
                end else if (w_expired) begin
                    w_next = S_RESP;
                end
            end
            S_WB:       w_next = S_RESP;
            S_RESP:     if (rsp_ready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_status    <= ST_OK;
            r_opcode    <= '0;
            r_src_a     <= '0;
            r_src_b     <= '0;
            r_dst       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            r_busy      <= (w_next != S_IDLE);
            r_rsp_valid <= (w_next == S_RESP);
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_opcode <= cmd_opcode;
                        r_src_a  <= cmd_src_a;
                        r_src_b  <= cmd_src_b;
                        r_dst    <= cmd_dst;
                    end
                end
                S_RD_A: r_op_a <= reg_val;
                S_RD_B: r_op_b <= reg_val;
                S_WAIT_ALU: begin
                    if (alu_done) begin
                        r_result <= alu_result;
                        r_ovf    <= alu_ovf;
                    end else if (w_expired) begin
                        r_status <= ST_TMO;
                    end
                end
                S_WB:    r_status <= r_ovf ? ST_OVF : ST_OK;
                default: ;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign busy       = r_busy;
    assign reg_sel    = w_reg_sel;
    assign alu_start  = (r_state == S_EXEC);
    assign alu_opcode = r_opcode;
    assign alu_a      = r_op_a;
    assign alu_b      = r_op_b;
    assign wr_en      = (r_state == S_WB) && !r_ovf;
    assign wr_sel     = r_dst;
    assign wr_data    = r_result;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_status = r_status;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_alu_op_sequencer : directed bench with a cycle-timeline reference model |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_op_sequencer;
    import calc_pkg::*;

    localparam int unsigned TMO = 15;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_opcode = '0;
    logic [2:0] cmd_src_a = '0;
    logic [2:0] cmd_src_b = '0;
    logic [2:0] cmd_dst = '0;
    logic [2:0] reg_sel;
    logic [8:0] reg_val;
    logic       alu_start;
    logic [2:0] alu_opcode;
    logic [8:0] alu_a;
    logic [8:0] alu_b;
    logic       alu_done = 1'b0;
    logic [8:0] alu_result = '0;
    logic       alu_ovf = 1'b0;
    logic       wr_en;
    logic [2:0] wr_sel;
    logic [8:0] wr_data;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [1:0] rsp_status;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_op_sequencer #(.DW(9), .NREGS(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst), .reg_sel(reg_sel), .reg_val(reg_val),
        .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment register file: combinational read, write on strobe.
    logic [8:0] regs [8] = '{9'd0, 9'd5, 9'd3, 9'd2, 9'd0, 9'd0, 9'd0, 9'd0};
    assign reg_val = regs[reg_sel];
    always @(posedge clk) if (wr_en) regs[wr_sel] <= wr_data;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle k counted from the accept edge; done at cycle d
    // means write-back at d+1 and response from d+2, timeout after TMO waits.
    bit         m_active = 1'b0;
    int         m_k = 0;
    int         m_wb = 0;
    int         m_resp = 0;
    logic [2:0] m_op = '0, m_sa = '0, m_sb = '0, m_dst = '0;
    logic [8:0] m_a = '0, m_b = '0, m_res = '0;
    logic       m_ovf = 1'b0;
    logic [1:0] m_status = '0;
    logic [8:0] m_regs [8] = '{9'd0, 9'd5, 9'd3, 9'd2, 9'd0, 9'd0, 9'd0, 9'd0};

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_wb     <= 0;
            m_resp   <= 0;
        end else if (!m_active) begin
            if (cmd_valid) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_wb     <= 0;
                m_resp   <= 0;
                m_op     <= cmd_opcode;
                m_sa     <= cmd_src_a;
                m_sb     <= cmd_src_b;
                m_dst    <= cmd_dst;
            end
        end else begin
            if (m_k == 1) m_a <= m_regs[m_sa];
            if (m_k == 2) m_b <= m_regs[m_sb];
            if (m_k >= 4 && m_wb == 0 && m_resp == 0) begin
                if (alu_done) begin
                    m_wb  <= m_k + 1;
                    m_res <= alu_result;
                    m_ovf <= alu_ovf;
                end else if (m_k == 3 + int'(TMO)) begin
                    m_resp   <= m_k + 1;
                    m_status <= 2'b10;
                end
            end
            if (m_wb != 0 && m_k == m_wb) begin
                m_resp   <= m_k + 1;
                m_status <= m_ovf ? 2'b01 : 2'b00;
                if (!m_ovf) m_regs[m_dst] <= m_res;
            end
            if (m_resp != 0 && m_k >= m_resp && rsp_ready) m_active <= 1'b0;
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        int  exp_sel;
        bit  exp_wr;
        bit  exp_rsp;
        exp_sel = (m_active && m_k == 1) ? int'(m_sa) : (m_active && m_k == 2) ? int'(m_sb) : 0;
        exp_wr  = m_active && m_wb != 0 && m_k == m_wb && !m_ovf;
        exp_rsp = m_active && m_resp != 0 && m_k >= m_resp;
        chk("busy", int'(busy), int'(m_active));
        chk("cmd_ready", int'(cmd_ready), int'(!m_active));
        chk("reg_sel", int'(reg_sel), exp_sel);
        chk("alu_start", int'(alu_start), int'(m_active && m_k == 3));
        chk("wr_en", int'(wr_en), int'(exp_wr));
        chk("rsp_valid", int'(rsp_valid), int'(exp_rsp));
        if (exp_wr) begin
            chk("wr_sel", int'(wr_sel), int'(m_dst));
            chk("wr_data", int'(wr_data), int'(m_res));
        end
        if (exp_rsp) chk("rsp_status", int'(rsp_status), int'(m_status));
        if (m_active && m_k >= 3) begin
            chk("alu_a", int'(alu_a), int'(m_a));
            chk("alu_b", int'(alu_b), int'(m_b));
            chk("alu_opcode", int'(alu_opcode), int'(m_op));
        end
    end

    // Issues one command from an idle sequencer; dly=0 means the ALU never answers.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                           input logic [2:0] dst, input int dly, input logic [8:0] res,
                           input logic ovf, input int rdy_dly,
                           output int wr_c, output int rsp_c, output int st,
                           output int a3, output int b3);
        int  c;
        bit  done;
        wr_c = -1; rsp_c = -1; st = -1; a3 = -1; b3 = -1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        c = 1;
        done = 1'b0;
        while (!done && c < 60) begin
            alu_done   = (dly != 0 && c == 3 + dly);
            alu_result = res;
            alu_ovf    = ovf;
            if (c == 3) begin a3 = int'(alu_a); b3 = int'(alu_b); end
            if (wr_en && wr_c < 0) wr_c = c;
            if (rsp_valid && rsp_c < 0) begin rsp_c = c; st = int'(rsp_status); end
            rsp_ready = (rsp_c >= 0 && c >= rsp_c + rdy_dly);
            @(posedge clk); #1;
            if (rsp_ready) done = 1'b1;
            c++;
        end
        rsp_ready = 1'b0;
        alu_done  = 1'b0;
        if (!done) chk("cmd_bound", c, 0);
    endtask

    initial begin
        int wr_c, rsp_c, st, a3, b3, acc2, hold, seen;

        repeat (2) @(posedge clk); #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_alu_start", int'(alu_start), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        nrst = 1'b1;
        @(posedge clk); #1;

        // ADD r1(5)+r2(3) -> r4, done one cycle after start
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd4, 1, 9'd8, 1'b0, 0, wr_c, rsp_c, st, a3, b3);
        chk("add_wr_cycle", wr_c, 5);
        chk("add_rsp_cycle", rsp_c, 6);
        chk("add_status", st, 0);
        chk("add_r4", int'(regs[4]), 8);

        // Overflow: no write, r4 keeps 8
        run_cmd(OP_ADD, 3'd1, 3'd2, 3'd4, 2, 9'h0FF, 1'b1, 1, wr_c, rsp_c, st, a3, b3);
        chk("ovf_wr_cycle", wr_c, -1);
        chk("ovf_rsp_cycle", rsp_c, 7);
        chk("ovf_status", st, 1);
        chk("ovf_r4", int'(regs[4]), 8);

        // ALU silent: 15 wait cycles (4..18) then timeout response
        run_cmd(OP_SUB, 3'd1, 3'd2, 3'd5, 0, 9'd0, 1'b0, 0, wr_c, rsp_c, st, a3, b3);
        chk("tmo_wr_cycle", wr_c, -1);
        chk("tmo_rsp_cycle", rsp_c, 19);
        chk("tmo_status", st, 2);

        // Done on the final wait cycle beats the timeout
        run_cmd(OP_OR, 3'd1, 3'd2, 3'd7, 15, 9'd7, 1'b0, 0, wr_c, rsp_c, st, a3, b3);
        chk("edge_wr_cycle", wr_c, 19);
        chk("edge_rsp_cycle", rsp_c, 20);
        chk("edge_status", st, 0);
        chk("edge_r7", int'(regs[7]), 7);

        // Same register as both sources and destination
        run_cmd(OP_ADD, 3'd3, 3'd3, 3'd3, 1, 9'd4, 1'b0, 2, wr_c, rsp_c, st, a3, b3);
        chk("alias_alu_a", a3, 2);
        chk("alias_alu_b", b3, 2);
        chk("alias_status", st, 0);
        chk("alias_r3", int'(regs[3]), 4);

        // cmd_valid held high; response stalled 4 cycles
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd5;
        @(posedge clk); #1;
        cmd_src_a = 3'd1; cmd_src_b = 3'd1; cmd_dst = 3'd6;
        acc2 = -1; hold = 0;
        for (int c = 1; c <= 17; c++) begin
            if (c == 12) cmd_valid = 1'b0;
            alu_done   = (c == 4 || c == 15);
            alu_result = (c == 4) ? 9'd8 : 9'd10;
            alu_ovf    = 1'b0;
            rsp_ready  = (c == 10 || c == 17);
            if (cmd_ready && acc2 < 0) acc2 = c;
            if (rsp_valid && c <= 10) hold++;
            @(posedge clk); #1;
        end
        alu_done = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b0;
        chk("b2b_accept2_cycle", acc2, 11);
        chk("b2b_rsp_hold", hold, 5);
        chk("b2b_r5", int'(regs[5]), 8);
        chk("b2b_r6", int'(regs[6]), 10);

        // Reset asserted while waiting on the ALU
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd6;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 2) nrst = 1'b1;
            if (wr_en || rsp_valid || busy) seen++;
        end
        chk("mid_rst_no_activity", seen, 0);
        chk("mid_rst_r6", int'(regs[6]), 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
